// File: rtl/ctrl_resolve_unit.sv
// ctrl_resolve_unit: resolves control-ALU results into a fetch redirect and a
// queue of branch-predictor updates.
// Optional feature macro: CTRL_UPD_BYPASS_EN. When it is defined, a push into an
// empty update FIFO whose consumer is ready goes straight to the upd outputs and
// is not stored.
`timescale 1ns/1ps

`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module ctrl_resolve_unit #(
    parameter int unsigned UPD_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   exeValid_i,
    output logic                   exeReady_o,
    input  logic [`SIZE_PC-1:0]    exePC_i,
    input  logic [`SIZE_PC-1:0]    exeNextPC_i,
    input  logic                   exeDir_i,
    input  logic                   exeMispredict_i,
    input  logic                   exeIsPredicted_i,
    input  logic                   exeIsControl_i,
    input  logic [`SIZE_CTI_LOG:0] exeAge_i,
    output logic                   redirectValid_o,
    input  logic                   redirectReady_i,
    output logic [`SIZE_PC-1:0]    redirectPC_o,
    output logic                   updValid_o,
    input  logic                   updReady_i,
    output logic [`SIZE_PC-1:0]    updPC_o,
    output logic [`SIZE_PC-1:0]    updTarget_o,
    output logic                   updDir_o,
    input  logic                   flush_i
);

    localparam int unsigned PtrW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned AgeW = `SIZE_CTI_LOG + 1;
    localparam int unsigned PcW  = `SIZE_PC;
    localparam logic [CntW-1:0] FullCnt = CntW'(UPD_DEPTH);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    // Handshake decode
    logic exe_accept;
    logic ctrl_accept;
    logic push;
    logic mispredict_accept;
    logic bypass_take;
    logic push_fifo;
    logic pop_fifo;
    logic fifo_empty;
    logic fifo_full;

    // FIFO state
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [PcW-1:0]  mem_pc_q  [UPD_DEPTH];
    logic [PcW-1:0]  mem_tgt_q [UPD_DEPTH];
    logic            mem_dir_q [UPD_DEPTH];

    // Redirect FSM state
    state_e          state_q;
    logic            redirect_valid_q;
    logic [PcW-1:0]  redirect_pc_q;
    logic [AgeW-1:0] held_age_q;
    logic [AgeW-1:0] age_diff;
    logic            new_is_older;
    logic            upd_valid;

    assign fifo_empty        = (count_q == '0);
    assign fifo_full         = (count_q == FullCnt);
    assign exeReady_o        = !fifo_full;
    assign exe_accept        = exeValid_i & exeReady_o;
    assign ctrl_accept       = exe_accept & exeIsControl_i;
    assign push              = ctrl_accept & (exeIsPredicted_i | exeMispredict_i);
    assign mispredict_accept = ctrl_accept & exeMispredict_i;

`ifdef CTRL_UPD_BYPASS_EN
    // An empty FIFO with a ready consumer hands the result straight through.
    assign bypass_take = push & fifo_empty & updReady_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign push_fifo = push & !bypass_take;
    assign pop_fifo  = !fifo_empty & updReady_i;
    assign upd_valid = !fifo_empty | bypass_take;

    // Age tags wrap: the new tag is older when the modular difference is negative.
    assign age_diff     = exeAge_i - held_age_q;
    assign new_is_older = age_diff[AgeW-1];

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fifo) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_fifo && !pop_fifo) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_fifo && pop_fifo) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // FIFO storage; stale entries are never visible because the outputs are gated.
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            mem_pc_q[wr_ptr_q]  <= exePC_i;
            mem_tgt_q[wr_ptr_q] <= exeNextPC_i;
            mem_dir_q[wr_ptr_q] <= exeDir_i;
        end
    end

    // Update outputs: FIFO head, bypassed input, or zero when nothing is offered.
    always_comb begin
        updValid_o  = upd_valid;
        updPC_o     = mem_pc_q[rd_ptr_q];
        updTarget_o = mem_tgt_q[rd_ptr_q];
        updDir_o    = mem_dir_q[rd_ptr_q];
        if (bypass_take) begin
            updPC_o     = exePC_i;
            updTarget_o = exeNextPC_i;
            updDir_o    = exeDir_i;
        end
        if (!upd_valid) begin
            updPC_o     = '0;
            updTarget_o = '0;
            updDir_o    = 1'b0;
        end
    end

    // Redirect FSM with registered valid/PC; flush overrides every transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            held_age_q       <= '0;
        end else if (flush_i) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mispredict_accept) begin
                        state_q          <= StRedirect;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= exeNextPC_i;
                        held_age_q       <= exeAge_i;
                    end
                end
                StRedirect: begin
                    if (redirect_valid_q && redirectReady_i) begin
                        // Current redirect consumed; a concurrent mispredict starts a fresh one.
                        if (mispredict_accept) begin
                            redirect_pc_q <= exeNextPC_i;
                            held_age_q    <= exeAge_i;
                        end else begin
                            state_q          <= StIdle;
                            redirect_valid_q <= 1'b0;
                        end
                    end else if (mispredict_accept && new_is_older) begin
                        redirect_pc_q <= exeNextPC_i;
                        held_age_q    <= exeAge_i;
                    end
                end
                default: begin
                    state_q          <= StIdle;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirectValid_o = redirect_valid_q;
    assign redirectPC_o    = redirect_pc_q;

endmodule

// File: doc/ctrl_resolve_unit.md
CTRL_RESOLVE_UNIT -- requirements
Module: ctrl_resolve_unit

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 4, meaning the update FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port exeValid_i, input, 1 bit: a control-ALU result is presented this cycle.
REQ-005 SHALL have port exeReady_o, output, 1 bit: a result is accepted on any cycle where exeValid_i and exeReady_o are both high.
REQ-006 SHALL have ports exePC_i and exeNextPC_i, input, `SIZE_PC` bits each: branch PC and resolved target.
REQ-007 SHALL have ports exeDir_i, exeMispredict_i, exeIsPredicted_i and exeIsControl_i, input, 1 bit each: the resolved direction and flags.
REQ-008 SHALL have port exeAge_i, input, `SIZE_CTI_LOG`+1 bits: branch age tag with a wrap bit.
REQ-009 SHALL have ports redirectValid_o, output, 1 bit; redirectReady_i, input, 1 bit; redirectPC_o, output, `SIZE_PC` bits: the fetch redirect handshake.
REQ-010 SHALL have ports updValid_o, output, 1 bit; updReady_i, input, 1 bit; updPC_o, output, `SIZE_PC`; updTarget_o, output, `SIZE_PC`; updDir_o, output, 1 bit: the predictor update handshake.
REQ-011 SHALL have port flush_i, input, 1 bit: pipeline recovery complete; any pending redirect is dropped.

Function
REQ-012 SHALL ignore an accepted result whose exeIsControl_i is 0: no push and no redirect.
REQ-013 SHALL push each accepted control result into the update FIFO as {PC, nextPC, dir} when exeIsPredicted_i is 1 or exeMispredict_i is 1.
REQ-014 SHALL drive exeReady_o = !full, where full means count == UPD_DEPTH.
REQ-015 SHALL, when full, accept a push in the same cycle as a pop only while exeReady_o is low, which means never; a full FIFO always blocks input.
REQ-016 SHALL present the FIFO head on the upd outputs with updValid_o = !empty, pop on updValid_o & updReady_i, and wrap the pointers modulo UPD_DEPTH.
REQ-017 SHALL, on a simultaneous push and pop at non-full, leave the count unchanged and keep data order FIFO.
REQ-018 SHALL implement a redirect FSM with states IDLE and REDIRECT.
REQ-019 SHALL move IDLE -> REDIRECT on an accepted control result with exeMispredict_i = 1, registering redirectPC = exeNextPC_i and the age; redirectValid_o rises the next cycle.
REQ-020 SHALL, in REDIRECT, replace the held PC and age with a new mispredict only if it is older, i.e. MSB of (newAge - heldAge) modulo 2^(`SIZE_CTI_LOG`+1) is 1; otherwise it is ignored.
REQ-021 SHALL hold redirectValid_o and redirectPC_o stable until redirectReady_i, unless a replacement occurs under REQ-020.
REQ-022 SHALL move REDIRECT -> IDLE on redirectValid_o & redirectReady_i. A simultaneous new mispredict SHALL re-enter REDIRECT next cycle with the new target.
REQ-023 SHALL give flush_i priority over everything in the FSM: next state IDLE and redirectValid_o low. Results arriving in the same cycle SHALL be dropped from the FSM only.
REQ-024 SHALL NOT clear the FIFO on flush_i.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set FSM = IDLE, FIFO pointers and count = 0, redirectValid_o = 0, updValid_o = 0, and redirectPC_o, updPC_o, updTarget_o and updDir_o = 0; exeReady_o = 1.
REQ-026 SHALL discard all held state on reset asserted mid-handshake; no output is retained after reset_n rises.

Configuration
REQ-027 SHALL support macro CTRL_UPD_BYPASS_EN. When defined and the FIFO is empty with updReady_i high, an accepted push SHALL appear on the upd outputs in the same cycle and SHALL NOT be enqueued (0-cycle latency). When undefined, updValid_o for the first entry rises 1 cycle after the push.

Verification
REQ-028 SHALL verify: single BEQ result, predicted, no mispredict, PC=0x400100, target=0x400120, dir=1, updReady_i=1 -> updValid_o next cycle with those values; redirectValid_o stays 0.
REQ-029 SHALL verify: mispredict with age 5 and target 0x400200, then age 3 and target 0x400300 while redirectReady_i=0 -> redirectPC_o becomes 0x400300; a later age 7 leaves it unchanged.
REQ-030 SHALL verify: age wrap with held age 0x1E then new age 0x02 (5-bit tag) -> treated as younger, ignored.
REQ-031 SHALL verify: 4 pushes with updReady_i=0 -> exeReady_o=0 after the 4th; 1 pop -> exeReady_o=1; order preserved.
REQ-032 SHALL verify: flush_i in REDIRECT -> redirectValid_o=0 next cycle, FIFO count unchanged; reset_n low mid-REDIRECT -> all outputs 0 and exeReady_o=1 immediately.
REQ-033 SHALL verify: with CTRL_UPD_BYPASS_EN, push to an empty FIFO with updReady_i=1 -> updValid_o in the same cycle and count stays 0.
